fetch_sequencer: RTL and testbench

Control FSM that drives the Instruction Unit, which has PC, synchronous instruction ROM, IR and sign-extend. It sequences fetch (ROM read, then IR load with PC+4), hands each instruction to the execute datapath via a start/done handshake, and then applies the PC redirect (jump, branch, jr) or an interrupt vector load. It sits between the top-level CPU control and the Instruction Unit control pins.

---
 rtl/fetch_pkg.sv | 51 +++++
 rtl/fetch_decode.sv | 52 +++++
 rtl/fetch_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer and its decode helper.
// Holds the FSM state encodings, the redirect classification, MIPS opcode and
// funct values, the PC source select codes, and a helper that decides whether
// a finished instruction needs a PC redirect.
package fetch_pkg;

  // FSM states. The numeric values also appear on the debug state output.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_LOAD     = 3'd2,
    S_DECODE   = 3'd3,
    S_EXEC     = 3'd4,
    S_REDIRECT = 3'd5,
    S_BOUNDARY = 3'd6,
    S_INTR     = 3'd7
  } state_t;

  // Kinds of PC redirect an instruction can request once it has executed.
  typedef enum logic [1:0] {
    RK_NONE   = 2'd0,
    RK_JUMP   = 2'd1,
    RK_BRANCH = 2'd2,
    RK_JR     = 2'd3
  } redir_kind_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_BREAK = 6'b001101;

  localparam logic [1:0] SEL_IN   = 2'b00;
  localparam logic [1:0] SEL_JMP  = 2'b01;
  localparam logic [1:0] SEL_BR   = 2'b10;
  localparam logic [1:0] SEL_HOLD = 2'b11;

  // Jumps and jr always redirect; a branch redirects only when its condition
  // was true in the cycle execute reported completion.
  function automatic logic takes_redirect(input redir_kind_t kind, input logic taken);
    case (kind)
      RK_JUMP, RK_JR: return 1'b1;
      RK_BRANCH:      return taken;
      default:        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fetch_decode.sv
// Combinational classifier for the instruction held in the IR.
// Ports:
//   ir          : instruction word from the Instruction Unit IR
//   redir_kind  : which PC redirect this instruction will request
//   pc_sel      : PC source to use if the redirect is taken (hold otherwise)
//   is_break    : instruction is BREAK
module fetch_decode
  import fetch_pkg::*;
(
  input  logic [31:0] ir,
  output redir_kind_t redir_kind,
  output logic [1:0]  pc_sel,
  output logic        is_break
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_ir;

  assign opcode    = ir[31:26];
  assign funct     = ir[5:0];
  assign unused_ir = ^ir[25:6];

  // Only the opcode and, for R-type, the funct field matter here. Anything
  // that is not a control-flow instruction keeps the PC source at hold so a
  // stray load enable could never move the PC.
  always_comb begin
    redir_kind = RK_NONE;
    pc_sel     = SEL_HOLD;
    is_break   = 1'b0;
    case (opcode)
      OP_J, OP_JAL: begin
        redir_kind = RK_JUMP;
        pc_sel     = SEL_JMP;
      end
      OP_BEQ, OP_BNE: begin
        redir_kind = RK_BRANCH;
        pc_sel     = SEL_BR;
      end
      OP_RTYPE: begin
        if (funct == FN_JR) begin
          redir_kind = RK_JR;
          pc_sel     = SEL_IN;
        end else if (funct == FN_BREAK) begin
          is_break = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Control FSM driving the Instruction Unit: fetches each instruction from the
// synchronous ROM, loads it into the IR while stepping the PC, hands it to the
// execute datapath, then applies any PC redirect and services interrupts at
// the instruction boundary.
// Ports:
//   clk, reset          : clock and asynchronous active-low reset
//   run                 : level, keep fetching/executing while high
//   ir                  : current IR contents
//   ex_done, br_taken   : execute completion pulse and branch outcome
//   int_req             : level interrupt request
//   pc_ld, pc_inc       : PC load / PC+4 enables (never both)
//   pc_sel              : PC source select during a load
//   im_cs, im_rd        : ROM chip select and read
//   ir_ld               : IR load enable
//   ex_start            : one-cycle execute start pulse
//   int_ack             : one-cycle pulse when the interrupt vector loads
//   halted              : BREAK has executed; cleared only by reset
//   state               : current state encoding, for debug
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int MEM_WAIT = 0,
  parameter int CW       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [31:0] ir,
  input  logic        ex_done,
  input  logic        br_taken,
  input  logic        int_req,
  output logic        pc_ld,
  output logic        pc_inc,
  output logic [1:0]  pc_sel,
  output logic        im_cs,
  output logic        im_rd,
  output logic        ir_ld,
  output logic        ex_start,
  output logic        int_ack,
  output logic        halted,
  output logic [2:0]  state
);

  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_WAIT);
  localparam logic [CW-1:0] WAIT_ONE  = CW'(1);

  state_t      state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  redir_kind_t kind_q, kind_d;
  logic [1:0]  sel_q, sel_d;
  logic        brk_q, brk_d;
  logic        halted_q, halted_d;

  redir_kind_t dec_kind;
  logic [1:0]  dec_sel;
  logic        dec_break;

  fetch_decode u_decode (
    .ir         (ir),
    .redir_kind (dec_kind),
    .pc_sel     (dec_sel),
    .is_break   (dec_break)
  );

  // State register plus the pending-redirect record captured in DECODE.
  // Reset drops everything back to IDLE at once, even in the middle of a
  // ROM access, and is the only way to leave the halted condition.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      wait_q   <= '0;
      kind_q   <= RK_NONE;
      sel_q    <= SEL_IN;
      brk_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      kind_q   <= kind_d;
      sel_q    <= sel_d;
      brk_q    <= brk_d;
      halted_q <= halted_d;
    end
  end

  // Next-state logic. The wait counter only advances inside FETCH and is
  // zero on every other cycle, so each fetch starts counting from scratch.
  // The redirect kind is latched in DECODE because the IR may not be stable
  // for the whole execute phase. Interrupts are only considered at BOUNDARY,
  // which is after any redirect has already been applied.
  always_comb begin
    state_d  = state_q;
    wait_d   = '0;
    kind_d   = kind_q;
    sel_d    = sel_q;
    brk_d    = brk_q;
    halted_d = halted_q;
    case (state_q)
      S_IDLE: begin
        if (run && !halted_q) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (wait_q == WAIT_LAST) state_d = S_LOAD;
        else                     wait_d  = wait_q + WAIT_ONE;
      end
      S_LOAD: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        kind_d  = dec_kind;
        sel_d   = dec_sel;
        brk_d   = dec_break;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (ex_done) begin
          if (brk_q) begin
            halted_d = 1'b1;
            state_d  = S_IDLE;
          end else if (takes_redirect(kind_q, br_taken)) begin
            state_d = S_REDIRECT;
          end else begin
            state_d = S_BOUNDARY;
          end
        end
      end
      S_REDIRECT: begin
        state_d = S_BOUNDARY;
      end
      S_BOUNDARY: begin
        if (int_req)  state_d = S_INTR;
        else if (run) state_d = S_FETCH;
        else          state_d = S_IDLE;
      end
      S_INTR: begin
        state_d = run ? S_FETCH : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore output decode. LOAD is the only state that steps the PC and the
  // only state that loads the IR; REDIRECT and INTR are the only states that
  // load the PC, so pc_inc and pc_ld can never overlap.
  always_comb begin
    pc_ld    = 1'b0;
    pc_inc   = 1'b0;
    pc_sel   = SEL_IN;
    im_cs    = 1'b0;
    im_rd    = 1'b0;
    ir_ld    = 1'b0;
    ex_start = 1'b0;
    int_ack  = 1'b0;
    case (state_q)
      S_FETCH: begin
        im_cs = 1'b1;
        im_rd = 1'b1;
      end
      S_LOAD: begin
        im_cs  = 1'b1;
        im_rd  = 1'b1;
        ir_ld  = 1'b1;
        pc_inc = 1'b1;
      end
      S_DECODE: begin
        ex_start = 1'b1;
      end
      S_REDIRECT: begin
        pc_ld  = 1'b1;
        pc_sel = sel_q;
      end
      S_INTR: begin
        pc_ld   = 1'b1;
        pc_sel  = SEL_IN;
        int_ack = 1'b1;
      end
      default: ;
    endcase
  end

  assign halted = halted_q;
  assign state  = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer. A small Instruction Unit model
// (PC register and IR) reacts to the DUT control pins so that PC movement can
// be checked against hand-computed addresses. A second instance with
// MEM_WAIT=3 covers the stretched fetch and asynchronous reset mid-fetch.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  localparam logic [31:0] VECTOR = 32'h0000_0200;

  typedef struct {
    logic [31:0] word;
    logic        br;
    int          n;
    int          exp_lat;
    logic        exp_ld;
    logic [1:0]  exp_sel;
    logic [31:0] exp_pc;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, run, ex_done, br_taken, int_req;
  logic [31:0] ir;
  logic        pc_ld, pc_inc, im_cs, im_rd, ir_ld, ex_start, int_ack, halted;
  logic [1:0]  pc_sel;
  logic [2:0]  state;

  logic        reset2, run2;
  logic [31:0] ir2;
  logic        ex_done2, br_taken2, int_req2;
  logic        pc_ld2, pc_inc2, im_cs2, im_rd2, ir_ld2, ex_start2, int_ack2, halted2;
  logic [1:0]  pc_sel2;
  logic [2:0]  state2;

  logic [31:0] pc, rom_word, pc_in_val;
  int          checks = 0;
  int          fails = 0;
  vec_t        vecs[9];

  always #5 clk = ~clk;

  fetch_sequencer #(.MEM_WAIT(0), .CW(4)) dut (
    .clk(clk), .reset(reset), .run(run), .ir(ir), .ex_done(ex_done),
    .br_taken(br_taken), .int_req(int_req), .pc_ld(pc_ld), .pc_inc(pc_inc),
    .pc_sel(pc_sel), .im_cs(im_cs), .im_rd(im_rd), .ir_ld(ir_ld),
    .ex_start(ex_start), .int_ack(int_ack), .halted(halted), .state(state)
  );

  fetch_sequencer #(.MEM_WAIT(3), .CW(4)) dut_wait (
    .clk(clk), .reset(reset2), .run(run2), .ir(ir2), .ex_done(ex_done2),
    .br_taken(br_taken2), .int_req(int_req2), .pc_ld(pc_ld2), .pc_inc(pc_inc2),
    .pc_sel(pc_sel2), .im_cs(im_cs2), .im_rd(im_rd2), .ir_ld(ir_ld2),
    .ex_start(ex_start2), .int_ack(int_ack2), .halted(halted2), .state(state2)
  );

  // Instruction Unit model: IR captures the ROM word on ir_ld, PC steps by 4
  // on pc_inc, and on pc_ld takes the jump target, the branch target
  // (relative to the already-incremented PC), or PC_in, which carries the
  // interrupt vector while int_ack is high and the jr target otherwise.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= 32'h0;
      ir <= 32'h0;
    end else begin
      if (ir_ld) ir <= rom_word;
      if (pc_inc) pc <= pc + 32'd4;
      else if (pc_ld) begin
        case (pc_sel)
          2'b01:   pc <= {pc[31:28], ir[25:0], 2'b00};
          2'b10:   pc <= pc + {{14{ir[15]}}, ir[15:0], 2'b00};
          default: pc <= int_ack ? VECTOR : pc_in_val;
        endcase
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Runs one instruction from the next FETCH to its BOUNDARY on the main DUT,
  // pulsing ex_done in the n-th EXEC cycle, and reports what was observed.
  task automatic applyStimulus(input vec_t v, output int lat, output logic ld_seen,
                               output logic [1:0] sel_seen, output int ld_cnt,
                               output int irld_cnt, output logic excl_bad,
                               output logic timeout);
    logic started;
    int   exec_cnt;
    started  = 1'b0;
    exec_cnt = 0;
    lat      = 0;
    ld_seen  = 1'b0;
    sel_seen = 2'b11;
    ld_cnt   = 0;
    irld_cnt = 0;
    excl_bad = 1'b0;
    timeout  = 1'b1;
    rom_word = v.word;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (state == S_FETCH) started = 1'b1;
      if (started) lat++;
      if (pc_ld) begin
        ld_seen  = 1'b1;
        sel_seen = pc_sel;
        ld_cnt++;
      end
      if (pc_ld && pc_inc) excl_bad = 1'b1;
      if (ir_ld) irld_cnt++;
      if (state == S_EXEC) begin
        exec_cnt++;
        ex_done  = (exec_cnt == v.n);
        br_taken = v.br;
      end else begin
        ex_done  = 1'b0;
        br_taken = 1'b0;
      end
      if (started && state == S_BOUNDARY) begin
        timeout = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    int         lat, ld_cnt, irld_cnt, exec_cnt, nfetch;
    logic       ld_seen, excl_bad, timeout, flag;
    logic [1:0] sel_seen;
    logic [2:0] trace[9];
    state_t     exp_int[9];
    state_t     exp_drop[7];
    logic [3:0] redir_obs, intr_obs;

    vecs[0] = '{32'h2008_0005, 1'b0, 1, 5, 1'b0, 2'b00, 32'h0000_0004};
    vecs[1] = '{32'h0800_0010, 1'b0, 1, 6, 1'b1, 2'b01, 32'h0000_0040};
    vecs[2] = '{32'h1000_0003, 1'b0, 2, 6, 1'b0, 2'b00, 32'h0000_0044};
    vecs[3] = '{32'h1000_0003, 1'b1, 1, 6, 1'b1, 2'b10, 32'h0000_0054};
    vecs[4] = '{32'h1400_FFFF, 1'b1, 1, 6, 1'b1, 2'b10, 32'h0000_0054};
    vecs[5] = '{32'h03E0_0008, 1'b0, 3, 8, 1'b1, 2'b00, 32'h0000_0100};
    vecs[6] = '{32'h0C00_0020, 1'b0, 1, 6, 1'b1, 2'b01, 32'h0000_0080};
    vecs[7] = '{32'h2008_0005, 1'b1, 1, 5, 1'b0, 2'b00, 32'h0000_0084};
    vecs[8] = '{32'h0000_0020, 1'b1, 2, 6, 1'b0, 2'b00, 32'h0000_0088};

    exp_int  = '{S_FETCH, S_LOAD, S_DECODE, S_EXEC, S_EXEC, S_REDIRECT, S_BOUNDARY, S_INTR, S_IDLE};
    exp_drop = '{S_FETCH, S_LOAD, S_DECODE, S_EXEC, S_BOUNDARY, S_IDLE, S_IDLE};

    reset = 1'b0; run = 1'b0; ex_done = 1'b0; br_taken = 1'b0; int_req = 1'b0;
    reset2 = 1'b0; run2 = 1'b0; ir2 = 32'h0; ex_done2 = 1'b0; br_taken2 = 1'b0; int_req2 = 1'b0;
    rom_word = 32'h0; pc_in_val = 32'h0000_0100;

    // Reset state and idling with run low.
    repeat (2) @(negedge clk);
    checkOutput("reset outputs",
                32'({pc_ld, pc_inc, pc_sel, im_cs, im_rd, ir_ld, ex_start, int_ack, halted, state}), 32'h0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("idle with run low", 32'(state), 32'(S_IDLE));
    checkOutput("no fetch with run low", 32'(im_cs), 32'h0);
    run = 1'b1;

    // Table of single instructions executed back to back.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i], lat, ld_seen, sel_seen, ld_cnt, irld_cnt, excl_bad, timeout);
      checkOutput($sformatf("v%0d timeout", i), 32'(timeout), 32'h0);
      checkOutput($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      checkOutput($sformatf("v%0d pc_ld count", i), 32'(ld_cnt), 32'(vecs[i].exp_ld));
      if (vecs[i].exp_ld)
        checkOutput($sformatf("v%0d pc_sel", i), 32'(sel_seen), 32'(vecs[i].exp_sel));
      checkOutput($sformatf("v%0d pc", i), pc, vecs[i].exp_pc);
      checkOutput($sformatf("v%0d ir_ld count", i), 32'(irld_cnt), 32'h1);
      checkOutput($sformatf("v%0d ld/inc overlap", i), 32'(excl_bad), 32'h0);
    end

    // Interrupt raised during a jr: redirect first, then the vector load.
    rom_word  = 32'h03E0_0008;
    pc_in_val = 32'h0000_0300;
    exec_cnt  = 0;
    irld_cnt  = 0;
    redir_obs = 4'h0;
    intr_obs  = 4'h0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      trace[c] = state;
      if (ir_ld) irld_cnt++;
      if (state == S_REDIRECT) redir_obs = {1'b1, pc_ld, pc_sel};
      if (state == S_INTR) intr_obs = {int_ack, pc_ld, pc_sel};
      if (state == S_EXEC) begin
        exec_cnt++;
        int_req = 1'b1;
        ex_done = (exec_cnt == 2);
      end else begin
        ex_done = 1'b0;
      end
      if (state == S_INTR) run = 1'b0;
    end
    for (int c = 0; c < 9; c++)
      checkOutput($sformatf("intr trace %0d", c), 32'(trace[c]), 32'(exp_int[c]));
    checkOutput("jr redirect ld/sel", 32'(redir_obs), 32'hC);
    checkOutput("intr ack/ld/sel", 32'(intr_obs), 32'hC);
    checkOutput("intr ir_ld count", 32'(irld_cnt), 32'h1);
    checkOutput("pc after vector", pc, VECTOR);
    flag = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (state != S_IDLE || int_ack) flag = 1'b1;
    end
    checkOutput("int_req ignored in idle", 32'(flag), 32'h0);
    int_req = 1'b0;

    // Dropping run mid-instruction: it completes, then idles at the boundary.
    rom_word = 32'h2008_0005;
    run = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      trace[c] = state;
      if (state == S_EXEC) begin
        run     = 1'b0;
        ex_done = 1'b1;
      end else begin
        ex_done = 1'b0;
      end
    end
    for (int c = 0; c < 7; c++)
      checkOutput($sformatf("drop-run trace %0d", c), 32'(trace[c]), 32'(exp_drop[c]));

    // BREAK halts; run is ignored until reset.
    rom_word = 32'h0000_000D;
    run = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      ex_done = (state == S_EXEC);
    end
    ex_done = 1'b0;
    checkOutput("halted after break", 32'(halted), 32'h1);
    checkOutput("state while halted", 32'(state), 32'h0);
    flag = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (im_cs || state != 3'd0 || !halted) flag = 1'b1;
    end
    checkOutput("stays halted, no fetch", 32'(flag), 32'h0);
    reset = 1'b0;
    #1;
    checkOutput("reset clears halted", 32'(halted), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("fetch resumes after reset", 32'(state), 32'(S_FETCH));
    run = 1'b0;

    // MEM_WAIT=3 instance: asynchronous reset in the 2nd FETCH cycle, then a
    // full four-cycle fetch after release.
    reset2 = 1'b1;
    run2   = 1'b1;
    nfetch = 0;
    flag   = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (state2 == S_FETCH) nfetch++;
      if (nfetch == 2) begin
        checkOutput("wait fetch im_cs", 32'(im_cs2), 32'h1);
        reset2 = 1'b0;
        #1;
        checkOutput("async reset mid-fetch",
                    32'({pc_ld2, pc_inc2, pc_sel2, im_cs2, im_rd2, ir_ld2, ex_start2, int_ack2, halted2, state2}),
                    32'h0);
        flag = 1'b0;
        break;
      end
    end
    checkOutput("reach 2nd fetch cycle", 32'(flag), 32'h0);
    @(negedge clk);
    reset2 = 1'b1;
    nfetch = 0;
    flag   = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (state2 == S_FETCH) nfetch++;
      else if (nfetch > 0) begin
        checkOutput("state after wait fetch", 32'(state2), 32'(S_LOAD));
        flag = 1'b0;
        break;
      end
    end
    checkOutput("wait fetch ended", 32'(flag), 32'h0);
    checkOutput("wait fetch cycles", 32'(nfetch), 32'd4);
    run2 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
